// File: rtl/aes_key_schedule_pkg.sv
// Shared AES key-schedule definitions: sizes, FSM state type, round-key
// payload, the S-box table and the SubWord / Rcon helpers.
package aes_key_schedule_pkg;

  localparam int unsigned AES_KEY_LENGTH       = 256;
  localparam int unsigned AES_BLOCK_SIZE       = 128;
  localparam int unsigned AES_NUMBER_OF_ROUNDS = 14;
  localparam int unsigned AES_ROUND_KEY_COUNT  = AES_NUMBER_OF_ROUNDS + 1;
  localparam int unsigned AES_WORD_W           = 32;
  localparam int unsigned AES_INDEX_W          = 4;

  localparam logic [AES_INDEX_W-1:0] AES_LAST_INDEX =
    AES_INDEX_W'(AES_ROUND_KEY_COUNT - 1);

  typedef enum logic {
    KS_IDLE = 1'b0,
    KS_EMIT = 1'b1
  } ks_state_e;

  typedef struct packed {
    logic [AES_BLOCK_SIZE-1:0] key;
    logic [AES_INDEX_W-1:0]    index;
    logic                      last;
  } round_key_t;

  // Forward S-box; entry 0 is the leftmost element.
  localparam logic [0:255][7:0] AES_SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // SubWord: S-box applied to each byte of a word.
  function automatic logic [AES_WORD_W-1:0] aes_sub_word(input logic [AES_WORD_W-1:0] w);
    return {AES_SBOX[w[31:24]], AES_SBOX[w[23:16]], AES_SBOX[w[15:8]], AES_SBOX[w[7:0]]};
  endfunction

  // Rcon byte for AES-256 rotation step j (1..7).
  function automatic logic [7:0] aes_rcon(input logic [2:0] j);
    logic [7:0] rc;
    rc = 8'h00;
    case (j)
      3'd1:    rc = 8'h01;
      3'd2:    rc = 8'h02;
      3'd3:    rc = 8'h04;
      3'd4:    rc = 8'h08;
      3'd5:    rc = 8'h10;
      3'd6:    rc = 8'h20;
      3'd7:    rc = 8'h40;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_key_schedule_expander.sv
// Combinational AES-256 round-key expander.
// Ports: round_number (2..14), input_key = previous eight key words
// (word 1 in the MSBs), round_key_c = next four expanded words.
module aes_key_expander
  import aes_key_schedule_pkg::*;
(
  input  logic [AES_INDEX_W-1:0]    round_number,
  input  logic [AES_KEY_LENGTH-1:0] input_key,
  output logic [AES_BLOCK_SIZE-1:0] round_key_c
);

  logic [AES_WORD_W-1:0] win_c [8];
  logic [AES_WORD_W-1:0] wout_c [4];
  logic [AES_WORD_W-1:0] temp_c;

  // Even rounds start a new 8-word group (RotWord+SubWord+Rcon); odd rounds use SubWord only.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      win_c[i] = input_key[AES_KEY_LENGTH-1-AES_WORD_W*i -: AES_WORD_W];
    end
    if (!round_number[0]) begin
      temp_c = aes_sub_word({win_c[7][23:0], win_c[7][31:24]}) ^
               {aes_rcon(round_number[3:1]), 24'h000000};
    end else begin
      temp_c = aes_sub_word(win_c[7]);
    end
    wout_c[0] = win_c[0] ^ temp_c;
    for (int i = 1; i < 4; i++) begin
      wout_c[i] = win_c[i] ^ wout_c[i-1];
    end
    round_key_c = {wout_c[0], wout_c[1], wout_c[2], wout_c[3]};
  end

endmodule

// File: rtl/aes_key_schedule.sv
// AES-256 round-key scheduler: accepts a 256-bit key and streams the 15
// round keys (index 0..14) over a valid/ready handshake.
// Ports: clk, rst_n (async, active-low), clear (sync abort);
//   key_in/key_in_valid/key_in_ready - key load handshake;
//   round_key/round_key_index/round_key_last/round_key_valid/round_key_ready
//   - round-key stream; busy - high while keys are being emitted.
module aes_key_schedule
  import aes_key_schedule_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic [AES_KEY_LENGTH-1:0] key_in,
  input  logic                      key_in_valid,
  output logic                      key_in_ready,
  output logic [AES_BLOCK_SIZE-1:0] round_key,
  output logic [AES_INDEX_W-1:0]    round_key_index,
  output logic                      round_key_last,
  output logic                      round_key_valid,
  input  logic                      round_key_ready,
  output logic                      busy
);

  ks_state_e                 state_q, state_d;
  logic [AES_KEY_LENGTH-1:0] window_q, window_d;
  round_key_t                rk_q, rk_d;
  logic                      key_in_ready_q, key_in_ready_d;
  logic                      round_key_valid_q, round_key_valid_d;
  logic                      busy_q, busy_d;
  logic [AES_BLOCK_SIZE-1:0] exp_key_c;

  // Expander looks at the next-cycle window/index so round_key can be registered.
  aes_key_expander u_expander (
    .round_number (rk_d.index),
    .input_key    (window_d),
    .round_key_c  (exp_key_c)
  );

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= KS_IDLE;
      window_q          <= '0;
      rk_q              <= '0;
      key_in_ready_q    <= 1'b0;
      round_key_valid_q <= 1'b0;
      busy_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      window_q          <= window_d;
      rk_q              <= rk_d;
      key_in_ready_q    <= key_in_ready_d;
      round_key_valid_q <= round_key_valid_d;
      busy_q            <= busy_d;
    end
  end

  // Next-state, window/index update and next outputs.
  always_comb begin
    state_d    = state_q;
    window_d   = window_q;
    rk_d       = rk_q;
    rk_d.index = rk_q.index;

    case (state_q)
      KS_IDLE: begin
        // key_in_ready_q gates capture so nothing is taken in the cycle after reset.
        if (!clear && key_in_ready_q && key_in_valid) begin
          window_d   = key_in;
          rk_d.index = '0;
          state_d    = KS_EMIT;
        end
      end
      KS_EMIT: begin
        if (clear) begin
          rk_d.index = '0;
          state_d    = KS_IDLE;
        end else if (round_key_ready) begin
          // Indices 0 and 1 are the key itself; later keys slide into the window.
          if (rk_q.index >= AES_INDEX_W'(2)) begin
            window_d = {window_q[AES_BLOCK_SIZE-1:0], rk_q.key};
          end
          if (rk_q.index == AES_LAST_INDEX) begin
            rk_d.index = '0;
            state_d    = KS_IDLE;
          end else begin
            rk_d.index = rk_q.index + AES_INDEX_W'(1);
          end
        end
      end
      default: begin
        state_d = KS_IDLE;
      end
    endcase

    if (rk_d.index == AES_INDEX_W'(0)) begin
      rk_d.key = window_d[AES_KEY_LENGTH-1:AES_BLOCK_SIZE];
    end else if (rk_d.index == AES_INDEX_W'(1)) begin
      rk_d.key = window_d[AES_BLOCK_SIZE-1:0];
    end else begin
      rk_d.key = exp_key_c;
    end
    rk_d.last = (state_d == KS_EMIT) && (rk_d.index == AES_LAST_INDEX);

    key_in_ready_d    = (state_d == KS_IDLE);
    round_key_valid_d = (state_d == KS_EMIT);
    busy_d            = (state_d == KS_EMIT);
  end

  assign key_in_ready    = key_in_ready_q;
  assign round_key       = rk_q.key;
  assign round_key_index = rk_q.index;
  assign round_key_last  = rk_q.last;
  assign round_key_valid = round_key_valid_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: a FIPS-197 key expansion model
// (S-box derived from GF(2^8) inversion) tracks what the stream must show.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic [255:0] key_in;
  logic         key_in_valid;
  logic         key_in_ready;
  logic [127:0] round_key;
  logic [3:0]   round_key_index;
  logic         round_key_last;
  logic         round_key_valid;
  logic         round_key_ready;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]          sb [256];
  bit                  m_active;
  bit                  m_armed;
  int                  m_idx;
  logic [14:0][127:0]  m_keys;

  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_schedule dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (clear),
    .key_in          (key_in),
    .key_in_valid    (key_in_valid),
    .key_in_ready    (key_in_ready),
    .round_key       (round_key),
    .round_key_index (round_key_index),
    .round_key_last  (round_key_last),
    .round_key_valid (round_key_valid),
    .round_key_ready (round_key_ready),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] b, inv, s;
    for (int v = 0; v < 256; v++) begin
      b   = 8'(v);
      inv = 8'h00;
      if (b != 8'h00)
        for (int c = 1; c < 256; c++)
          if (gmul(b, 8'(c)) == 8'h01) inv = 8'(c);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[v] = s;
    end
  endtask

  function automatic logic [31:0] sw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Textbook AES-256 expansion of all 60 words, grouped into 15 round keys.
  function automatic logic [14:0][127:0] expand(input logic [255:0] k);
    logic [31:0]        w [60];
    logic [31:0]        t;
    logic [7:0]         rc;
    logic [14:0][127:0] r;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = sw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = sw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int j = 0; j < 15; j++) r[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return r;
  endfunction

  // Behavioural model of the stream position.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_armed  <= 1'b0;
      m_idx    <= 0;
    end else begin
      m_armed <= 1'b1;
      if (clear) begin
        m_active <= 1'b0;
        m_idx    <= 0;
      end else if (m_active) begin
        if (round_key_ready) begin
          if (m_idx == 14) begin
            m_active <= 1'b0;
            m_idx    <= 0;
          end else begin
            m_idx <= m_idx + 1;
          end
        end
      end else if (m_armed && key_in_valid) begin
        m_active <= 1'b1;
        m_idx    <= 0;
        m_keys   <= expand(key_in);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("valid", 128'(round_key_valid), 128'(m_active));
      chk("busy", 128'(busy), 128'(m_active));
      chk("key_in_ready", 128'(key_in_ready), 128'(m_armed && !m_active));
      if (m_active) begin
        chk("round_key", round_key, m_keys[m_idx]);
        chk("index", 128'(round_key_index), 128'(m_idx));
        chk("last", 128'(round_key_last), 128'(m_idx == 14));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (m_active && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", 128'(m_active), 128'(0));
  endtask

  task automatic wait_idx(input int k, input int budget);
    int n = 0;
    while (!(m_active && m_idx == k) && n < budget) begin
      step();
      n++;
    end
    chk("idx_timeout", 128'(m_active && m_idx == k), 128'(1));
  endtask

  task automatic load(input logic [255:0] k);
    key_in       = k;
    key_in_valid = 1'b1;
    step();
    key_in_valid = 1'b0;
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [14:0][127:0] pin;
    logic [255:0]       kb;
    int                 gap;
    int                 n;

    rst_n = 1'b1; clear = 1'b0; key_in = '0; key_in_valid = 1'b0; round_key_ready = 1'b0;
    build_sbox();

    // Model pins against FIPS-197 A.3 and the all-zero key.
    pin = expand(KEY_A3);
    chk("model_a3_r0", pin[0], 128'h603deb1015ca71be2b73aef0857d7781);
    chk("model_a3_r2", pin[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    chk("model_a3_r14", pin[14], 128'hfe4890d1e6188d0b046df344706c631e);
    pin = expand(256'h0);
    chk("model_zero_r2", pin[2], 128'h62636363626363636263636362636363);

    // Reset state.
    #1 rst_n = 1'b0;
    #3;
    chk("rst_valid", 128'(round_key_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ready", 128'(key_in_ready), 128'(0));
    chk("rst_index", 128'(round_key_index), 128'(0));
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    step();

    // A.3 key with ready held high: 15 keys in 15 consecutive cycles.
    round_key_ready = 1'b1;
    key_in = KEY_A3; key_in_valid = 1'b1;
    step();
    key_in_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1)  chk("a3_idx0", round_key, 128'h603deb1015ca71be2b73aef0857d7781);
      if (k == 3)  chk("a3_idx2", round_key, 128'h9ba354118e6925afa51a8b5f2067fcde);
      if (k == 15) begin
        chk("a3_idx14", round_key, 128'hfe4890d1e6188d0b046df344706c631e);
        chk("a3_last", 128'(round_key_last), 128'(1));
      end
      if (k == 16) chk("a3_ready_t16", 128'(key_in_ready), 128'(1));
    end
    step();

    // Same key with random stalls of 0-5 cycles.
    load(KEY_A3);
    n = 0;
    while (m_active && n < 200) begin
      round_key_ready = 1'b0;
      repeat ($urandom_range(0, 5)) step();
      round_key_ready = 1'b1;
      step();
      n++;
    end
    wait_idle(20);

    // Clear in IDLE blocks capture.
    clear = 1'b1; key_in = KEY_A3; key_in_valid = 1'b1;
    step();
    clear = 1'b0; key_in_valid = 1'b0;
    @(negedge clk);
    chk("clear_blocks_capture", 128'(round_key_valid), 128'(0));
    step();

    // Clear at index 7 during a transfer, then reload.
    round_key_ready = 1'b1;
    load(KEY_A3);
    wait_idx(7, 20);
    clear = 1'b1;
    step();
    clear = 1'b0;
    @(negedge clk);
    chk("clear_valid", 128'(round_key_valid), 128'(0));
    chk("clear_ready", 128'(key_in_ready), 128'(1));
    step();
    load(KEY_A3);
    wait_idle(20);

    // Reset pulse at index 5.
    load(rand_key());
    wait_idx(5, 20);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 128'(round_key_valid), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    @(posedge clk); #2 rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("arst_ready_after", 128'(key_in_ready), 128'(1));
    step();
    load(rand_key());
    wait_idle(20);

    // Key_in_valid held through EMIT with a different key.
    kb = rand_key();
    key_in = KEY_A3; key_in_valid = 1'b1;
    step();
    key_in = kb;
    n = 0;
    while (m_active && n < 20) begin
      step();
      n++;
    end
    chk("hold_accept_cycle", 128'(n), 128'(15));
    step();
    key_in_valid = 1'b0;
    pin = expand(kb);
    @(negedge clk);
    chk("hold_second_r0", round_key, pin[0]);
    step();
    wait_idle(20);

    // Back-to-back zero then all-ones keys; Key_in_ready gap.
    key_in = '0; key_in_valid = 1'b1;
    step();
    key_in = '1;
    gap = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 3) chk("zero_idx2", round_key, 128'h62636363626363636263636362636363);
      if (key_in_ready) break;
      gap++;
    end
    chk("ready_gap", 128'(gap), 128'(15));
    step();
    key_in_valid = 1'b0;
    wait_idle(20);

    // Random keys, random back-pressure, stray key_in_valid and rare clears.
    for (int r = 0; r < 8; r++) begin
      step();
      round_key_ready = 1'($urandom_range(0, 1));
      load(rand_key());
      n = 0;
      while (m_active && n < 300) begin
        key_in_valid    = ($urandom_range(0, 3) == 0);
        key_in          = rand_key();
        round_key_ready = ($urandom_range(0, 2) != 0);
        clear           = ($urandom_range(0, 60) == 0);
        step();
        n++;
      end
      key_in_valid = 1'b0; clear = 1'b0; round_key_ready = 1'b1;
      step();
      wait_idle(20);
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
